// File: rtl/coin_pkg.sv
// coin_pkg: shared types and constants for the coin sequencer.
//   coin_e    - coin type, also used as the round-robin pointer
//   state_e   - issue FSM states
//   *_VALUE   - coin values in cents
//   coin_next - round-robin successor (NICKEL -> DIME -> QUARTER -> NICKEL)
package coin_pkg;

    typedef enum logic [1:0] {
        NICKEL  = 2'd0,
        DIME    = 2'd1,
        QUARTER = 2'd2
    } coin_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int NUM_COINS     = 3;
    localparam int NICKEL_VALUE  = 5;
    localparam int DIME_VALUE    = 10;
    localparam int QUARTER_VALUE = 25;

    function automatic coin_e coin_next(input coin_e c);
        case (c)
            NICKEL:  return DIME;
            DIME:    return QUARTER;
            default: return NICKEL;
        endcase
    endfunction

endpackage

// File: rtl/coin_rr_arbiter.sv
// coin_rr_arbiter: combinational 3-way round-robin arbiter.
//   req     - one request bit per coin type (bit index = coin_e)
//   ptr     - highest-priority type this round
//   gnt     - one-hot grant, zero when no request
//   nxt_ptr - type following the granted one (ptr when nothing granted)
//   any     - at least one request present
module coin_rr_arbiter
    import coin_pkg::*;
(
    input  logic [2:0] req,
    input  coin_e      ptr,
    output logic [2:0] gnt,
    output coin_e      nxt_ptr,
    output logic       any
);

    coin_e c0;
    coin_e c1;
    coin_e c2;

    // Search order starting at the pointer.
    assign c0  = ptr;
    assign c1  = coin_next(c0);
    assign c2  = coin_next(c1);
    assign any = |req;

    always_comb begin
        gnt     = '0;
        nxt_ptr = ptr;
        if (req[c0]) begin
            gnt[c0] = 1'b1;
            nxt_ptr = c1;
        end else if (req[c1]) begin
            gnt[c1] = 1'b1;
            nxt_ptr = c2;
        end else if (req[c2]) begin
            gnt[c2] = 1'b1;
            nxt_ptr = c0;
        end
    end

endmodule

// File: rtl/coin_sequencer.sv
// coin_sequencer: shares the vending machine's coin channel between three
// coin acceptors. Rising edges on the raw sensor lines are counted per type
// and replayed as one-hot single-cycle pulses separated by idle gaps, with
// round-robin fairness and a pause after every vend.
//   clk, reset_n             - clock, asynchronous active-low reset
//   coin_*_in                - raw sensor levels, rising edge = one coin
//   valid                    - vend achieved (rising edge counted)
//   nickel/dime/quarter      - registered one-cycle coin pulses
//   busy                     - coins pending or sequencer not idle
//   overflow                 - sticky: coin lost on a saturated counter
//   vend_count               - wrapping count of vends
module coin_sequencer
    import coin_pkg::*;
#(
    parameter int CNT_W       = 3,
    parameter int GAP_CYCLES  = 1,
    parameter int HOLD_CYCLES = 4,
    parameter int VEND_W      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              coin_nickel_in,
    input  logic              coin_dime_in,
    input  logic              coin_quarter_in,
    input  logic              valid,
    output logic              nickel,
    output logic              dime,
    output logic              quarter,
    output logic              busy,
    output logic              overflow,
    output logic [VEND_W-1:0] vend_count
);

    localparam int TMR_MAX = (GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES : HOLD_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);

    logic [2:0]       coin_in;
    logic [2:0]       coin_q;
    logic [2:0]       coin_ev;
    logic             valid_q;
    logic             vrise;
    logic [2:0]       req;
    logic [2:0]       gnt;
    logic [2:0]       take;
    logic [2:0]       drop;
    logic             arb_any;
    logic             grant_en;
    coin_e            ptr;
    coin_e            ptr_n;
    coin_e            arb_nxt;
    state_e           state;
    state_e           state_n;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_n;
    logic [2:0]       pulse_q;
    logic [2:0]       pulse_n;

    assign coin_in = {coin_quarter_in, coin_dime_in, coin_nickel_in};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coin_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            coin_q  <= coin_in;
            valid_q <= valid;
        end
    end

    assign coin_ev = coin_in & ~coin_q;
    assign vrise   = valid & ~valid_q;
    assign take    = grant_en ? gnt : 3'b000;

    // One saturating pending counter per coin type.
    for (genvar i = 0; i < NUM_COINS; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt;

        assign req[i]  = (cnt != '0);
        // A grant in the same cycle frees a slot, so only an ungranted event
        // on a full counter loses a coin.
        assign drop[i] = coin_ev[i] & ~take[i] & (cnt == CNT_MAX);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt <= '0;
            end else if (coin_ev[i] && !take[i]) begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (!coin_ev[i] && take[i]) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    coin_rr_arbiter u_arb (
        .req     (req),
        .ptr     (ptr),
        .gnt     (gnt),
        .nxt_ptr (arb_nxt),
        .any     (arb_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            tmr     <= '0;
            ptr     <= NICKEL;
            pulse_q <= '0;
        end else begin
            state   <= state_n;
            tmr     <= tmr_n;
            ptr     <= ptr_n;
            pulse_q <= pulse_n;
        end
    end

    // The last cycle of GAP or HOLD may grant directly, so back-to-back coins
    // are spaced 1+GAP_CYCLES apart without an extra IDLE cycle. A vend edge
    // always wins over a grant.
    always_comb begin
        logic can_grant;
        can_grant = 1'b0;
        state_n   = state;
        tmr_n     = tmr;
        ptr_n     = ptr;
        pulse_n   = '0;
        grant_en  = 1'b0;

        case (state)
            IDLE: begin
                if (vrise) begin
                    state_n = HOLD;
                    tmr_n   = HOLD_LOAD;
                end else begin
                    can_grant = 1'b1;
                end
            end
            PULSE: begin
                if (vrise) begin
                    state_n = HOLD;
                    tmr_n   = HOLD_LOAD;
                end else begin
                    state_n = GAP;
                    tmr_n   = GAP_LOAD;
                end
            end
            GAP: begin
                if (vrise) begin
                    state_n = HOLD;
                    tmr_n   = HOLD_LOAD;
                end else if (tmr == '0) begin
                    can_grant = 1'b1;
                end else begin
                    tmr_n = tmr - TMR_W'(1);
                end
            end
            HOLD: begin
                if (vrise) begin
                    tmr_n = HOLD_LOAD;
                end else if (tmr == '0) begin
                    can_grant = 1'b1;
                end else begin
                    tmr_n = tmr - TMR_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        if (can_grant) begin
            state_n = IDLE;
            if (arb_any) begin
                state_n  = PULSE;
                pulse_n  = gnt;
                ptr_n    = arb_nxt;
                grant_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            vend_count <= '0;
        end else begin
            if (|drop) begin
                overflow <= 1'b1;
            end
            if (vrise) begin
                vend_count <= vend_count + VEND_W'(1);
            end
        end
    end

    assign nickel  = pulse_q[NICKEL];
    assign dime    = pulse_q[DIME];
    assign quarter = pulse_q[QUARTER];
    assign busy    = (|req) | (state != IDLE);

endmodule

// File: tb/tb_coin_sequencer.sv
// tb_coin_sequencer: directed bench for coin_sequencer with a timing-level
// reference model (pending counts, round-robin pointer and the earliest
// cycle a new coin may be issued) checked every cycle, plus hand-computed
// expectations for each scenario.
module tb_coin_sequencer;
    import coin_pkg::*;

    localparam int CNT_W   = 3;
    localparam int GAP     = 1;
    localparam int HOLD    = 4;
    localparam int VEND_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              coin_nickel_in = 1'b0;
    logic              coin_dime_in = 1'b0;
    logic              coin_quarter_in = 1'b0;
    logic              valid = 1'b0;
    logic              nickel;
    logic              dime;
    logic              quarter;
    logic              busy;
    logic              overflow;
    logic [VEND_W-1:0] vend_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mon_type[$];
    int mon_cyc[$];

    coin_sequencer #(
        .CNT_W       (CNT_W),
        .GAP_CYCLES  (GAP),
        .HOLD_CYCLES (HOLD),
        .VEND_W      (VEND_W)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .coin_nickel_in  (coin_nickel_in),
        .coin_dime_in    (coin_dime_in),
        .coin_quarter_in (coin_quarter_in),
        .valid           (valid),
        .nickel          (nickel),
        .dime            (dime),
        .quarter         (quarter),
        .busy            (busy),
        .overflow        (overflow),
        .vend_count      (vend_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_pend[3];
    int m_ptr = 0;
    int m_ready = 0;
    int m_e = 0;
    bit m_prev[3];
    bit m_vprev = 1'b0;
    bit m_ovf = 1'b0;
    int m_vend = 0;
    bit [2:0] exp_coin = 3'b000;
    bit exp_busy = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        bit ev[3];
        bit vr;
        int g;
        int c;
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                m_pend[i] = 0;
                m_prev[i] = 1'b0;
            end
            m_ptr = 0; m_ready = 0; m_e = 0; m_vprev = 1'b0;
            m_ovf = 1'b0; m_vend = 0; exp_coin = 3'b000; exp_busy = 1'b0;
        end else begin
            ev[0] = coin_nickel_in  && !m_prev[0];
            ev[1] = coin_dime_in    && !m_prev[1];
            ev[2] = coin_quarter_in && !m_prev[2];
            vr    = valid && !m_vprev;
            g = -1;
            if (vr) begin
                m_vend  = (m_vend + 1) % (1 << VEND_W);
                m_ready = m_e + HOLD;
            end else if (m_e >= m_ready) begin
                for (int j = 0; j < 3; j++) begin
                    c = (m_ptr + j) % 3;
                    if (g < 0 && m_pend[c] > 0) g = c;
                end
                if (g >= 0) begin
                    m_pend[g]--;
                    m_ptr   = (g + 1) % 3;
                    m_ready = m_e + 1 + GAP;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (ev[i]) begin
                    if (m_pend[i] == CNT_MAX) m_ovf = 1'b1;
                    else m_pend[i]++;
                end
            end
            exp_coin = (g >= 0) ? 3'(1 << g) : 3'b000;
            exp_busy = (m_pend[0] + m_pend[1] + m_pend[2] > 0) || (m_e < m_ready);
            m_e++;
            m_prev[0] = coin_nickel_in;
            m_prev[1] = coin_dime_in;
            m_prev[2] = coin_quarter_in;
            m_vprev   = valid;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("nickel", int'(nickel), int'(exp_coin[0]));
        chk("dime", int'(dime), int'(exp_coin[1]));
        chk("quarter", int'(quarter), int'(exp_coin[2]));
        chk("busy", int'(busy), int'(exp_busy));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("vend_count", int'(vend_count), m_vend);
    end

    // Pulse log: coin type and cycle index of each issued pulse.
    always @(negedge clk) begin
        if (nickel)  begin mon_type.push_back(int'(NICKEL));  mon_cyc.push_back(cyc); end
        if (dime)    begin mon_type.push_back(int'(DIME));    mon_cyc.push_back(cyc); end
        if (quarter) begin mon_type.push_back(int'(QUARTER)); mon_cyc.push_back(cyc); end
    end

    task automatic set_coins(input logic n, input logic d, input logic q);
        coin_nickel_in  = n;
        coin_dime_in    = d;
        coin_quarter_in = q;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_coins(1'b0, 1'b0, 1'b0);
        valid = 1'b0;
        #2 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        mon_type.delete();
        mon_cyc.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int a;
        int v;
        int k;
        int n_dime;

        // Test 1: reset with toggling inputs, then single nickel latency
        reset_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            coin_nickel_in  = ~coin_nickel_in;
            coin_dime_in    = ~coin_dime_in;
            coin_quarter_in = ~coin_quarter_in;
            valid           = ~valid;
        end
        chk("rst_coins", int'({nickel, dime, quarter}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_vend", int'(vend_count), 0);
        chk("rst_ovf", int'(overflow), 0);
        @(negedge clk);
        set_coins(1'b0, 1'b0, 1'b0);
        valid = 1'b0;
        #2 reset_n = 1'b1;
        @(negedge clk);
        coin_nickel_in = 1'b1;
        @(negedge clk);
        coin_nickel_in = 1'b0;
        chk("t1_before_pulse", int'(nickel), 0);
        chk("t1_busy_pending", int'(busy), 1);
        @(negedge clk);
        chk("t1_pulse", int'(nickel), 1);
        @(negedge clk);
        chk("t1_width", int'(nickel), 0);
        chk("t1_busy_gap", int'(busy), 1);
        @(negedge clk);
        chk("t1_busy_idle", int'(busy), 0);

        // Test 2: all three coins in one cycle
        do_reset();
        @(negedge clk);
        set_coins(1'b1, 1'b1, 1'b1);
        k = cyc + 1;
        @(negedge clk);
        set_coins(1'b0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        chk("t2_count", mon_type.size(), 3);
        if (mon_type.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("t2_order", mon_type[i], i);
                chk("t2_time", mon_cyc[i], k + 1 + 2 * i);
            end
        end
        chk("t2_busy_end", int'(busy), 0);

        // Test 3: four quarters, vend, then queued nickel/dime after hold
        do_reset();
        a = cyc + 2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            coin_quarter_in = 1'b1;
            @(negedge clk);
            coin_quarter_in = 1'b0;
        end
        @(negedge clk);
        valid = 1'b1;
        set_coins(1'b1, 1'b1, 1'b0);
        v = cyc + 1;
        @(negedge clk);
        valid = 1'b0;
        set_coins(1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        chk("t3_vend", int'(vend_count), 1);
        chk("t3_count", mon_type.size(), 6);
        if (mon_type.size() == 6) begin
            for (int i = 0; i < 4; i++) begin
                chk("t3_q_type", mon_type[i], int'(QUARTER));
                chk("t3_q_time", mon_cyc[i], a + 1 + 2 * i);
            end
            chk("t3_n_type", mon_type[4], int'(NICKEL));
            chk("t3_n_time", mon_cyc[4], v + HOLD);
            chk("t3_d_type", mon_type[5], int'(DIME));
            chk("t3_d_time", mon_cyc[5], v + HOLD + 2);
        end

        // Test 4: nine dimes during a held vend -> saturation at seven
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            coin_dime_in = 1'b1;
            valid = 1'b1;
            @(negedge clk);
            coin_dime_in = 1'b0;
            valid = 1'b0;
            if (i == 6) chk("t4_no_ovf_at7", int'(overflow), 0);
            if (i == 7) chk("t4_ovf_at8", int'(overflow), 1);
        end
        repeat (30) @(negedge clk);
        n_dime = 0;
        foreach (mon_type[i]) if (mon_type[i] == int'(DIME)) n_dime++;
        chk("t4_dime_pulses", n_dime, 7);
        chk("t4_total_pulses", mon_type.size(), 7);
        chk("t4_ovf_sticky", int'(overflow), 1);
        chk("t4_vend", int'(vend_count), 9);
        chk("t4_busy_end", int'(busy), 0);

        // Test 5: interleaved nickel and dime streams alternate
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_coins(1'b1, 1'b1, 1'b0);
            @(negedge clk);
            set_coins(1'b0, 1'b0, 1'b0);
        end
        repeat (20) @(negedge clk);
        chk("t5_count", mon_type.size(), 12);
        if (mon_type.size() == 12) begin
            for (int i = 0; i < 12; i++) chk("t5_alternate", mon_type[i], i % 2);
        end
        chk("t5_ovf", int'(overflow), 0);

        // Test 6: asynchronous reset in the middle of a pulse
        do_reset();
        @(negedge clk);
        set_coins(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        set_coins(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        set_coins(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        set_coins(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("t6_dime_pulse", int'(dime), 1);
        chk("t6_busy_before", int'(busy), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_async_coins", int'({nickel, dime, quarter}), 0);
        chk("t6_async_busy", int'(busy), 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        mon_type.delete();
        mon_cyc.delete();
        repeat (10) @(negedge clk);
        chk("t6_no_pulses", mon_type.size(), 0);
        chk("t6_busy_end", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coin_sequencer.md
Name: coin_sequencer

Overview:
Front-end controller for vendingMachine that accepts raw coin-acceptor lines (nickel/dime/quarter) and shares the machine's single coin channel between the three coin types. Coin insertions are edge-detected, counted per type, and replayed as clean one-hot single-cycle pulses with enforced idle gaps. The block is fairly arbitrated (round-robin), pauses while a vend is signalled by vendingMachine.valid, and keeps pending/overflow/vend status for the host.

Parameters:
CNT_W, 3, width of each per-type pending counter (saturates at 2**CNT_W-1)
GAP_CYCLES, 1, idle cycles forced after every coin pulse (>=1)
HOLD_CYCLES, 4, cycles coin issue is suspended after valid is seen (>=1)
VEND_W, 8, width of vend_count

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
coin_nickel_in  input  1  raw nickel sensor level; rising edge = one coin
coin_dime_in  input  1  raw dime sensor level; rising edge = one coin
coin_quarter_in  input  1  raw quarter sensor level; rising edge = one coin
valid  input  1  from vendingMachine: vend achieved
nickel  output  1  to vendingMachine, one-cycle pulse
dime  output  1  to vendingMachine, one-cycle pulse
quarter  output  1  to vendingMachine, one-cycle pulse
busy  output  1  high when any coin pending or FSM not IDLE
overflow  output  1  sticky: a coin was dropped on a saturated counter
vend_count  output  VEND_W  number of valid rising edges seen, wraps

Behaviour:
- Clock clk, reset reset_n: one clock, asynchronous active-low reset.
- Reset: nickel/dime/quarter=0, busy=0, overflow=0, vend_count=0; all pending counters=0; edge-detect registers=0; round-robin pointer=NICKEL; FSM=IDLE. Reset mid-pulse or mid-hold aborts immediately and discards pending coins.
- Edge detect: per input, in_q<=in each cycle; coin event = in & ~in_q. Multiple types may fire in the same cycle; each is counted.
- Pending counters: +1 on event, -1 on grant; both in one cycle = unchanged. Event on a saturated counter with no same-cycle grant: coin dropped, overflow<=1 (cleared only by reset).
- FSM states IDLE, PULSE, GAP, HOLD:
  - IDLE: if any counter nonzero, grant the first nonzero type at or after pointer (order NICKEL->DIME->QUARTER->NICKEL), decrement it, move to PULSE; pointer<=type after the granted one.
  - PULSE: exactly one of nickel/dime/quarter high for this single cycle (registered output); then GAP with gap counter=GAP_CYCLES.
  - GAP: all coin outputs 0; after GAP_CYCLES cycles -> IDLE.
  - HOLD: all coin outputs 0 for HOLD_CYCLES cycles, then IDLE. Pending counters still accept events.
- valid: rising edge of valid (registered compare) increments vend_count (mod 2**VEND_W) and forces HOLD from IDLE or GAP. If seen during PULSE, the pulse completes and HOLD replaces GAP. valid during HOLD restarts the hold counter.
- Latency: an event sampled at edge k with FSM IDLE and no other pending coin yields the output pulse high from edge k+1 to k+2. Minimum spacing between pulses = 1+GAP_CYCLES cycles.
- Outputs are always one-hot or zero; never two coin outputs high together.
- busy = (any counter !=0) | (state != IDLE).

Decomposition:
- Package coin_pkg: coin_e enum {NICKEL, DIME, QUARTER}, state_e enum {IDLE, PULSE, GAP, HOLD}, coin value constants (5/10/25) for benches.
- One sub-module: coin_rr_arbiter (3-way round-robin arbiter: request vector + pointer in, one-hot grant + next pointer out). Counters, edge detect and FSM stay in coin_sequencer.

Test Plan:
- Reset held 2 cycles with inputs toggling -> all outputs 0, vend_count=0, busy=0; after release, one nickel edge -> nickel pulse exactly 1 cycle, 1 cycle after the sample edge.
- Same-cycle rising edges on all three inputs, GAP_CYCLES=1 -> nickel, dime, quarter pulses in that order, 2 cycles apart; busy falls after the last gap.
- 4 quarter edges every 2 cycles -> 4 quarter pulses; valid pulsed after the 4th -> vend_count=1, no coin output for 4 cycles (HOLD), queued coins resume afterwards.
- 9 dime edges back-to-back-gapped while in HOLD, CNT_W=3 -> 7 counted, overflow=1, exactly 7 dime pulses issued.
- Continuous nickel and dime streams (edge every 2 cycles each) -> grants alternate nickel/dime; neither type starves; no cycle with two outputs high.
- Assert reset_n=0 during PULSE with 3 coins pending -> outputs drop to 0 asynchronously; after release, no further pulses.
